uart_rx_engine: RTL and testbench

- Receive-side serial engine of the full UART.
- Synchronises the RX line, detects and qualifies the start bit, samples each bit at mid-bit time and right-justifies the frame into a 10-bit shift register.
- Drives the downstream stop-bit selector with shift-register bits 7/8/9 and the latched format select, takes its stop-bit result back, and raises RXRDY plus parity, framing and overrun status.

---
 rtl/uart_rx_engine_pkg.sv | 17 +
 rtl/uart_rx_bit_timer.sv | 34 +++
 rtl/uart_rx_engine.sv | 151 +++++++++++++++
 tb/tb_uart_rx_engine.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_engine_pkg.sv
// Shared definitions for the UART receive engine: state encoding, frame geometry.
package uart_rx_engine_pkg;

    localparam int SH_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2
    } rx_state_e;

    // Shifted bits per frame: data + optional parity + stop (start bit not stored).
    function automatic logic [3:0] frame_len(input logic eight, input logic pen);
        return 4'd8 + {3'b000, eight} + {3'b000, pen};
    endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-time counter for the receiver; flags the half-bit or full-bit point of the current bit.
module uart_rx_bit_timer #(
    parameter int K_W = 19
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [K_W-1:0] k_i,
    input  logic           run_i,
    input  logic           half_i,
    output logic           hit_o
);

    logic [K_W-1:0] btc_q;
    logic [K_W-1:0] keff;
    logic [K_W-1:0] half;
    logic [K_W-1:0] target;

    // k below 2 would make the half-bit target underflow, so clamp it.
    always_comb begin
        keff   = (k_i < K_W'(2)) ? K_W'(2) : k_i;
        half   = keff >> 1;
        target = half_i ? (half - K_W'(1)) : (keff - K_W'(1));
        hit_o  = run_i && (btc_q == target);
    end

    always_ff @(posedge clk) begin
        if (reset || !run_i || hit_o) begin
            btc_q <= '0;
        end else begin
            btc_q <= btc_q + K_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: start-bit qualification, mid-bit sampling, frame assembly and status flags.
module uart_rx_engine
    import uart_rx_engine_pkg::*;
#(
    parameter int K_W = 19
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic [K_W-1:0]  k,
    input  logic            eight,
    input  logic            pen,
    input  logic            ohel,
    input  logic            clr,
    input  logic            stop_bit,
    output logic [SH_W-1:0] rx_sh,
    output logic [1:0]      cfg_sel,
    output logic [7:0]      data_out,
    output logic            rxrdy,
    output logic            perr,
    output logic            ferr,
    output logic            ovf
);

    logic            sync1_q;
    logic            rxs_q;
    rx_state_e       state_q;
    logic [3:0]      bc_q;
    logic [SH_W-1:0] rx_sh_q;
    logic            eight_q;
    logic            pen_q;
    logic            ohel_q;
    logic            done_q;
    logic            rxrdy_q;
    logic            perr_q;
    logic            ferr_q;
    logic            ovf_q;
    logic [7:0]      data_out_q;

    logic            hit;
    logic [3:0]      n;
    logic [3:0]      shamt;
    logic [SH_W-1:0] shift_d;
    logic [SH_W-1:0] frame_d;
    logic            last_bit;
    logic            perr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rx;
            rxs_q   <= sync1_q;
        end
    end

    uart_rx_bit_timer #(
        .K_W (K_W)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .k_i    (k),
        .run_i  (state_q != IDLE),
        .half_i (state_q == START),
        .hit_o  (hit)
    );

    // On the last bit the frame lands right-justified with the vacated top bits forced to 1.
    always_comb begin
        n        = frame_len(eight_q, pen_q);
        shamt    = 4'(SH_W) - n;
        shift_d  = {rxs_q, rx_sh_q[SH_W-1:1]};
        frame_d  = (shift_d >> shamt) | ~({SH_W{1'b1}} >> shamt);
        last_bit = (bc_q + 4'd1) == n;
        perr_d   = pen_q & ((^rx_sh_q[6:0]) ^ (eight_q & rx_sh_q[7])
                          ^ (eight_q ? rx_sh_q[8] : rx_sh_q[7]) ^ ohel_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bc_q       <= '0;
            rx_sh_q    <= {SH_W{1'b1}};
            eight_q    <= 1'b0;
            pen_q      <= 1'b0;
            ohel_q     <= 1'b0;
            done_q     <= 1'b0;
            rxrdy_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    bc_q <= '0;
                    if (!rxs_q) begin
                        eight_q <= eight;
                        pen_q   <= pen;
                        ohel_q  <= ohel;
                        state_q <= START;
                    end
                end
                START: begin
                    if (hit) begin
                        state_q <= rxs_q ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (hit) begin
                        if (last_bit) begin
                            rx_sh_q <= frame_d;
                            bc_q    <= '0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            rx_sh_q <= shift_d;
                            bc_q    <= bc_q + 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A completed frame takes priority over a coincident read strobe.
            if (done_q) begin
                rxrdy_q    <= 1'b1;
                data_out_q <= {eight_q & rx_sh_q[7], rx_sh_q[6:0]};
                ferr_q     <= ~stop_bit;
                perr_q     <= perr_d;
                ovf_q      <= rxrdy_q & ~clr;
            end else if (clr) begin
                rxrdy_q <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end
        end
    end

    assign rx_sh    = rx_sh_q;
    assign cfg_sel  = {eight_q, pen_q};
    assign data_out = data_out_q;
    assign rxrdy    = rxrdy_q;
    assign perr     = perr_q;
    assign ferr     = ferr_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine with a behavioural stop-bit selector at k = 16.
module tb_uart_rx_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic [18:0] k = 19'd16;
    logic        eight = 1'b1;
    logic        pen = 1'b0;
    logic        ohel = 1'b0;
    logic        clr = 1'b0;
    logic        stop_bit;
    logic [9:0]  rx_sh;
    logic [1:0]  cfg_sel;
    logic [7:0]  data_out;
    logic        rxrdy;
    logic        perr;
    logic        ferr;
    logic        ovf;

    int errors = 0;
    int checks = 0;
    int riseCycle;

    always #5 clk = ~clk;

    uart_rx_engine #(.K_W(19)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .k        (k),
        .eight    (eight),
        .pen      (pen),
        .ohel     (ohel),
        .clr      (clr),
        .stop_bit (stop_bit),
        .rx_sh    (rx_sh),
        .cfg_sel  (cfg_sel),
        .data_out (data_out),
        .rxrdy    (rxrdy),
        .perr     (perr),
        .ferr     (ferr),
        .ovf      (ovf)
    );

    // External stop-bit selector: 7N -> d7, 7P/8N -> d8, 8P -> d9.
    always_comb begin
        stop_bit = 1'b1;
        case (cfg_sel)
            2'b00:   stop_bit = rx_sh[7];
            2'b01:   stop_bit = rx_sh[8];
            2'b10:   stop_bit = rx_sh[8];
            default: stop_bit = rx_sh[9];
        endcase
    end

    // One 16-clock bit per entry: start bit, then bits[0..n-1]; optional clr pulse or reset abort.
    task automatic sendFrame(input logic [9:0] bits, input int n, input int clrAt, input int abortAt);
        int total;
        logic prevRdy;
        total = 16 * (n + 1);
        prevRdy = rxrdy;
        riseCycle = -1;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            if (!prevRdy && rxrdy && riseCycle < 0) riseCycle = c;
            prevRdy = rxrdy;
            if (c == abortAt) begin
                reset = 1'b1;
                rx = 1'b1;
                clr = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            rx = (c < 16) ? 1'b0 : bits[c / 16 - 1];
            clr = (c == clrAt);
        end
        @(negedge clk);
        rx = 1'b1;
        clr = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic clearFlags();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rx_sh !== 10'h3FF) begin errors++; $display("[TB] FAIL reset_rx_sh: got %h expected %h", rx_sh, 10'h3FF); end
        checks++; if (cfg_sel !== 2'b00) begin errors++; $display("[TB] FAIL reset_cfg_sel: got %b expected %b", cfg_sel, 2'b00); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_out: got %h expected %h", data_out, 8'h00); end
        checks++; if (rxrdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_rxrdy: got %b expected 0", rxrdy); end
        checks++; if ({perr, ferr, ovf} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {perr, ferr, ovf}); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_8n1();
        eight = 1'b1; pen = 1'b0; ohel = 1'b0;
        sendFrame(10'h3A5, 9, -1, -1);
        checks++; if (riseCycle !== 156) begin errors++; $display("[TB] FAIL 8n1_rxrdy_cycle: got %0d expected 156", riseCycle); end
        checks++; if (rxrdy !== 1'b1) begin errors++; $display("[TB] FAIL 8n1_rxrdy: got %b expected 1", rxrdy); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("[TB] FAIL 8n1_data_out: got %h expected %h", data_out, 8'hA5); end
        checks++; if (rx_sh !== 10'h3A5) begin errors++; $display("[TB] FAIL 8n1_rx_sh: got %h expected %h", rx_sh, 10'h3A5); end
        checks++; if ({perr, ferr} !== 2'b00) begin errors++; $display("[TB] FAIL 8n1_perr_ferr: got %b expected 00", {perr, ferr}); end
        checks++; if (cfg_sel !== 2'b10) begin errors++; $display("[TB] FAIL 8n1_cfg_sel: got %b expected 10", cfg_sel); end
    endtask

    task automatic test_parity7();
        clearFlags();
        eight = 1'b0; pen = 1'b1; ohel = 1'b0;
        sendFrame(10'h141, 9, -1, -1);
        checks++; if (rx_sh !== 10'h341) begin errors++; $display("[TB] FAIL p7_good_rx_sh: got %h expected %h", rx_sh, 10'h341); end
        checks++; if (data_out !== 8'h41) begin errors++; $display("[TB] FAIL p7_good_data_out: got %h expected %h", data_out, 8'h41); end
        checks++; if (perr !== 1'b0) begin errors++; $display("[TB] FAIL p7_good_perr: got %b expected 0", perr); end
        checks++; if (ferr !== 1'b0) begin errors++; $display("[TB] FAIL p7_good_ferr: got %b expected 0", ferr); end
        clearFlags();
        sendFrame(10'h1C1, 9, -1, -1);
        checks++; if (rx_sh !== 10'h3C1) begin errors++; $display("[TB] FAIL p7_bad_rx_sh: got %h expected %h", rx_sh, 10'h3C1); end
        checks++; if (data_out !== 8'h41) begin errors++; $display("[TB] FAIL p7_bad_data_out: got %h expected %h", data_out, 8'h41); end
        checks++; if (perr !== 1'b1) begin errors++; $display("[TB] FAIL p7_bad_perr: got %b expected 1", perr); end
    endtask

    task automatic test_framing();
        clearFlags();
        eight = 1'b1; pen = 1'b1; ohel = 1'b1;
        sendFrame(10'h1FF, 10, -1, -1);
        checks++; if (ferr !== 1'b1) begin errors++; $display("[TB] FAIL 8p_ferr: got %b expected 1", ferr); end
        checks++; if (rx_sh !== 10'h1FF) begin errors++; $display("[TB] FAIL 8p_rx_sh: got %h expected %h", rx_sh, 10'h1FF); end
        checks++; if (cfg_sel !== 2'b11) begin errors++; $display("[TB] FAIL 8p_cfg_sel: got %b expected 11", cfg_sel); end
        checks++; if (perr !== 1'b0) begin errors++; $display("[TB] FAIL 8p_perr: got %b expected 0", perr); end
        checks++; if (data_out !== 8'hFF) begin errors++; $display("[TB] FAIL 8p_data_out: got %h expected %h", data_out, 8'hFF); end
        clearFlags();
        @(negedge clk);
        checks++; if (ferr !== 1'b0) begin errors++; $display("[TB] FAIL clr_ferr: got %b expected 0", ferr); end
        checks++; if (rxrdy !== 1'b0) begin errors++; $display("[TB] FAIL clr_rxrdy: got %b expected 0", rxrdy); end
        checks++; if (data_out !== 8'hFF) begin errors++; $display("[TB] FAIL clr_data_hold: got %h expected %h", data_out, 8'hFF); end
    endtask

    task automatic test_false_start();
        eight = 1'b1; pen = 1'b0; ohel = 1'b0;
        @(negedge clk);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (rxrdy !== 1'b0) begin errors++; $display("[TB] FAIL false_start_rxrdy: got %b expected 0", rxrdy); end
        checks++; if (rx_sh !== 10'h1FF) begin errors++; $display("[TB] FAIL false_start_rx_sh: got %h expected %h", rx_sh, 10'h1FF); end
    endtask

    task automatic test_back_to_back();
        eight = 1'b1; pen = 1'b0; ohel = 1'b0;
        sendFrame(10'h312, 9, -1, -1);
        sendFrame(10'h334, 9, -1, -1);
        checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL overrun_ovf: got %b expected 1", ovf); end
        checks++; if (data_out !== 8'h34) begin errors++; $display("[TB] FAIL overrun_data_out: got %h expected %h", data_out, 8'h34); end
        checks++; if (rxrdy !== 1'b1) begin errors++; $display("[TB] FAIL overrun_rxrdy: got %b expected 1", rxrdy); end
        sendFrame(10'h356, 9, 155, -1);
        checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL clr_at_done_ovf: got %b expected 0", ovf); end
        checks++; if (rxrdy !== 1'b1) begin errors++; $display("[TB] FAIL clr_at_done_rxrdy: got %b expected 1", rxrdy); end
        checks++; if (data_out !== 8'h56) begin errors++; $display("[TB] FAIL clr_at_done_data: got %h expected %h", data_out, 8'h56); end
    endtask

    task automatic test_reset_mid_frame();
        eight = 1'b1; pen = 1'b1; ohel = 1'b1;
        sendFrame(10'h2AB, 10, -1, 84);
        checks++; if (rx_sh !== 10'h3FF) begin errors++; $display("[TB] FAIL abort_rx_sh: got %h expected %h", rx_sh, 10'h3FF); end
        checks++; if (cfg_sel !== 2'b00) begin errors++; $display("[TB] FAIL abort_cfg_sel: got %b expected 00", cfg_sel); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL abort_data_out: got %h expected %h", data_out, 8'h00); end
        checks++; if (rxrdy !== 1'b0) begin errors++; $display("[TB] FAIL abort_rxrdy: got %b expected 0", rxrdy); end
        checks++; if ({perr, ferr, ovf} !== 3'b000) begin errors++; $display("[TB] FAIL abort_flags: got %b expected 000", {perr, ferr, ovf}); end
        repeat (5) @(negedge clk);
        eight = 1'b1; pen = 1'b0; ohel = 1'b0;
        sendFrame(10'h33C, 9, -1, -1);
        checks++; if (data_out !== 8'h3C) begin errors++; $display("[TB] FAIL post_abort_data: got %h expected %h", data_out, 8'h3C); end
        checks++; if (rx_sh !== 10'h33C) begin errors++; $display("[TB] FAIL post_abort_rx_sh: got %h expected %h", rx_sh, 10'h33C); end
        checks++; if (rxrdy !== 1'b1) begin errors++; $display("[TB] FAIL post_abort_rxrdy: got %b expected 1", rxrdy); end
        checks++; if ({perr, ferr, ovf} !== 3'b000) begin errors++; $display("[TB] FAIL post_abort_flags: got %b expected 000", {perr, ferr, ovf}); end
    endtask

    initial begin
        $display("[TB] uart_rx_engine directed tests starting");
        test_reset();
        test_8n1();
        test_parity7();
        test_framing();
        test_false_start();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
